// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
//   Hazard and sequencing controller for the EX stage of a five-stage MIPS
//   pipeline. It keeps its own shadow copy of the instructions sitting in
//   EX, MEM and WB, and from those it derives:
//     - operand forwarding selects for the instruction in EX,
//     - the load-use stall/bubble for the instruction in ID,
//     - the branch flush,
//     - a debug halt/single-step FSM that drains the back end and then
//       freezes every pipeline register.
//
// Ports
//   i_clk, i_reset_n        clock (rising edge), async active-low reset
//   i_id_*                  decoded fields of the instruction in ID
//   i_branch_taken          branch in EX resolved taken this cycle
//   i_halt_req              debug halt request (level)
//   i_step                  single-step pulse, honoured only while HALTED
//   o_fwd_a / o_fwd_b       forwarding selects: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   o_stall                 hold PC and IF/ID
//   o_bubble                zero the control fields entering ID/EX
//   o_flush                 clear IF/ID
//   o_pipe_en               global enable for every pipeline register
//   o_halted                pipeline is frozen
//   o_state                 FSM state: 0 RUN, 1 DRAIN, 2 HALTED, 3 STEP
//
// Handshake note: there is no valid/ready pair here. o_pipe_en is the single
// "advance" qualifier: a slot (and the real pipeline register it mirrors)
// only moves on a rising edge where o_pipe_en is 1.
// ----------------------------------------------------------------------------
module ex_hazard_ctrl #(
  parameter int REGS          = 5,
  parameter int CORTOCIRCUITO = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_id_valid,
  input  logic [REGS-1:0]          i_id_rs,
  input  logic [REGS-1:0]          i_id_rt,
  input  logic                     i_id_uses_rs,
  input  logic                     i_id_uses_rt,
  input  logic [REGS-1:0]          i_id_dst,
  input  logic                     i_id_reg_write,
  input  logic                     i_id_mem_read,
  input  logic                     i_branch_taken,
  input  logic                     i_halt_req,
  input  logic                     i_step,
  output logic [CORTOCIRCUITO-1:0] o_fwd_a,
  output logic [CORTOCIRCUITO-1:0] o_fwd_b,
  output logic                     o_stall,
  output logic                     o_bubble,
  output logic                     o_flush,
  output logic                     o_pipe_en,
  output logic                     o_halted,
  output logic [1:0]               o_state
);

  // --------------------------------------------------------------------------
  // Types and constants
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic            valid;
    logic [REGS-1:0] rs;
    logic [REGS-1:0] rt;
    logic            uses_rs;
    logic            uses_rt;
    logic [REGS-1:0] dst;
    logic            reg_write;
    logic            mem_read;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  localparam logic [CORTOCIRCUITO-1:0] FWD_RF  = CORTOCIRCUITO'(0);
  localparam logic [CORTOCIRCUITO-1:0] FWD_MEM = CORTOCIRCUITO'(1);
  localparam logic [CORTOCIRCUITO-1:0] FWD_WB  = CORTOCIRCUITO'(2);

  localparam logic [REGS-1:0] REG_ZERO = '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t state_q, state_d;
  slot_t  ex_q,  ex_d;
  slot_t  mem_q, mem_d;
  slot_t  wb_q,  wb_d;

  // Hazard terms shared by the output and slot logic.
  logic load_use;
  logic mem_hit_a, mem_hit_b;
  logic wb_hit_a,  wb_hit_b;

  // --------------------------------------------------------------------------
  // Load-use detection: a load in EX whose destination is read by ID.
  // $0 is never a real dependency.
  // --------------------------------------------------------------------------
  always_comb begin
    load_use = 1'b0;
    if (i_id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dst != REG_ZERO)) begin
      load_use = (i_id_uses_rs && (i_id_rs == ex_q.dst)) ||
                 (i_id_uses_rt && (i_id_rt == ex_q.dst));
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding matches. A load sitting in MEM has no ALU result to forward,
  // so it never matches from MEM; the load-use stall guarantees the consumer
  // only reaches EX once the load is in WB.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_hit_a = 1'b0;
    mem_hit_b = 1'b0;
    wb_hit_a  = 1'b0;
    wb_hit_b  = 1'b0;
    if (mem_q.valid && mem_q.reg_write && !mem_q.mem_read && (mem_q.dst != REG_ZERO)) begin
      mem_hit_a = ex_q.uses_rs && (ex_q.rs == mem_q.dst);
      mem_hit_b = ex_q.uses_rt && (ex_q.rt == mem_q.dst);
    end
    if (wb_q.valid && wb_q.reg_write && (wb_q.dst != REG_ZERO)) begin
      wb_hit_a = ex_q.uses_rs && (ex_q.rs == wb_q.dst);
      wb_hit_b = ex_q.uses_rt && (ex_q.rt == wb_q.dst);
    end
  end

  // The younger result (MEM) wins over the older one (WB).
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (ex_q.valid) begin
      if (mem_hit_a)     o_fwd_a = FWD_MEM;
      else if (wb_hit_a) o_fwd_a = FWD_WB;
      if (mem_hit_b)     o_fwd_b = FWD_MEM;
      else if (wb_hit_b) o_fwd_b = FWD_WB;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_RUN;
    else            state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // DRAIN always bubbles EX and always advances, so once EX and MEM are
        // empty the edge that leaves DRAIN also retires whatever is in WB:
        // the pipeline is fully empty on arrival in HALTED.
        if (!ex_q.valid && !mem_q.valid) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!i_halt_req) state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_STEP: begin
        state_d = ST_HALTED;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_stall   = 1'b0;
    o_bubble  = 1'b0;
    o_flush   = 1'b0;
    o_pipe_en = 1'b1;
    o_halted  = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP: begin
        // A taken branch replaces the ID instruction anyway, so it cancels
        // the load-use stall and lets the PC load the target.
        o_flush  = i_branch_taken;
        o_bubble = i_branch_taken || load_use;
        o_stall  = load_use && !i_branch_taken;
      end
      ST_DRAIN: begin
        o_stall  = 1'b1;
        o_bubble = 1'b1;
        o_flush  = i_branch_taken;
      end
      ST_HALTED: begin
        o_stall   = 1'b1;
        o_pipe_en = 1'b0;
        o_halted  = 1'b1;
      end
      default: begin
        o_stall   = 1'b0;
        o_pipe_en = 1'b1;
      end
    endcase
  end

  assign o_state = state_q;

  // --------------------------------------------------------------------------
  // Shadow slots
  // --------------------------------------------------------------------------
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (o_pipe_en) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (o_bubble || o_flush || !i_id_valid) begin
        ex_d = '0;
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.rs        = i_id_rs;
        ex_d.rt        = i_id_rt;
        ex_d.uses_rs   = i_id_uses_rs;
        ex_d.uses_rt   = i_id_uses_rt;
        ex_d.dst       = i_id_dst;
        ex_d.reg_write = i_id_reg_write;
        ex_d.mem_read  = i_id_mem_read;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Source-operand fields of the older slots are carried for debug
  // visibility only; nothing downstream reads them.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt,
                              wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt,
                              wb_q.mem_read};

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       branch_taken, halt_req, step_in;
  logic [2:0] fwd_a, fwd_b;
  logic       stall, bubble, flush, pipe_en, halted;
  logic [1:0] state;

  ex_hazard_ctrl #(.REGS(5), .CORTOCIRCUITO(3)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_id_valid     (id_valid),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_uses_rs   (id_uses_rs),
    .i_id_uses_rt   (id_uses_rt),
    .i_id_dst       (id_dst),
    .i_id_reg_write (id_reg_write),
    .i_id_mem_read  (id_mem_read),
    .i_branch_taken (branch_taken),
    .i_halt_req     (halt_req),
    .i_step         (step_in),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_stall        (stall),
    .o_bubble       (bubble),
    .o_flush        (flush),
    .o_pipe_en      (pipe_en),
    .o_halted       (halted),
    .o_state        (state)
  );

  // --------------------------------------------------------------------------
  // Scoreboard: {fwd_a, fwd_b, stall, bubble, flush, pipe_en, halted, state}
  // --------------------------------------------------------------------------
  logic [12:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic mr);
    id_valid = v;  id_rs = rs;  id_rt = rt;  id_uses_rs = urs;  id_uses_rt = urt;
    id_dst = dst;  id_reg_write = rw;  id_mem_read = mr;
  endtask

  task automatic id_nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // R-type: rd <- rs op rt
  task automatic id_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_id(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
  endtask

  // lw rt, 0(base)
  task automatic id_lw(input logic [4:0] rt, input logic [4:0] base);
    set_id(1'b1, base, rt, 1'b1, 1'b0, rt, 1'b1, 1'b1);
  endtask

  // One cycle: push expectation for the current inputs, compare at negedge,
  // then move to just after the next rising edge where new inputs go.
  task automatic step(input string tag, input logic [2:0] fa, input logic [2:0] fb,
                      input logic st, input logic bu, input logic fl,
                      input logic pe, input logic ha, input logic [1:0] s);
    logic [12:0] obs;
    logic [12:0] exp_v;
    string       t;
    exp_q.push_back({fa, fb, st, bu, fl, pe, ha, s});
    tag_q.push_back(tag);
    @(negedge clk);
    obs   = {fwd_a, fwd_b, stall, bubble, flush, pipe_en, halted, state};
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed fa=%0d fb=%0d st=%b bu=%b fl=%b pe=%b ha=%b s=%0d expected fa=%0d fb=%0d st=%b bu=%b fl=%b pe=%b ha=%b s=%0d",
             t, obs[12:10], obs[9:7], obs[6], obs[5], obs[4], obs[3], obs[2], obs[1:0],
             exp_v[12:10], exp_v[9:7], exp_v[6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
    end
    @(posedge clk);
    #1;
  endtask

  // Shorthands for the common output patterns.
  task automatic run_idle(input string tag, input logic [2:0] fa, input logic [2:0] fb);
    step(tag, fa, fb, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic halted_chk(input string tag);
    step(tag, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
  endtask

  task automatic drain_chk(input string tag);
    step(tag, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0;  halt_req = 1'b0;  step_in = 1'b0;
    id_nop();
    @(posedge clk);
    #1;
    run_idle("reset_vals", 3'd0, 3'd0);
    rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5 : EX/MEM forward on A only
    id_alu(5'd3, 5'd1, 5'd2);  run_idle("addsub_c1", 3'd0, 3'd0);
    id_alu(5'd4, 5'd3, 5'd5);  run_idle("addsub_c2", 3'd0, 3'd0);
    id_nop();                  run_idle("addsub_fwd", 3'd1, 3'd0);
                               run_idle("addsub_ex_empty", 3'd0, 3'd0);

    // add $3 ; nop ; or $6,$7,$3 : MEM/WB forward on B
    id_alu(5'd3, 5'd1, 5'd2);  run_idle("wb_c1", 3'd0, 3'd0);
    id_nop();                  run_idle("wb_c2", 3'd0, 3'd0);
    id_alu(5'd6, 5'd7, 5'd3);  run_idle("wb_c3", 3'd0, 3'd0);
    id_nop();                  run_idle("wb_fwd_b2", 3'd0, 3'd2);

    // Same shape with $0 as the producer: never forwarded
    id_alu(5'd0, 5'd1, 5'd2);  run_idle("r0_c1", 3'd0, 3'd0);
    id_nop();                  run_idle("r0_c2", 3'd0, 3'd0);
    id_alu(5'd6, 5'd7, 5'd0);  run_idle("r0_c3", 3'd0, 3'd0);
    id_nop();                  run_idle("r0_no_fwd", 3'd0, 3'd0);

    // Two producers of $3 back to back: MEM beats WB on both operands
    id_alu(5'd3, 5'd1, 5'd2);  run_idle("prio_c1", 3'd0, 3'd0);
    id_alu(5'd3, 5'd4, 5'd5);  run_idle("prio_c2", 3'd0, 3'd0);
    id_alu(5'd6, 5'd3, 5'd3);  run_idle("prio_c3", 3'd0, 3'd0);
    id_nop();                  run_idle("prio_mem_wins", 3'd1, 3'd1);

    // lw $8,0($9) ; add $10,$8,$8 : one stall, then MEM/WB forward on both
    id_lw(5'd8, 5'd9);         run_idle("lu_c1", 3'd0, 3'd0);
    id_alu(5'd10, 5'd8, 5'd8);
    step("lu_stall", 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
                               run_idle("lu_one_cycle", 3'd0, 3'd0);
    id_nop();                  run_idle("lu_fwd_both2", 3'd2, 3'd2);

    // Branch taken on top of a load-use: flush wins, no stall
    id_lw(5'd8, 5'd9);         run_idle("br_c1", 3'd0, 3'd0);
    id_alu(5'd10, 5'd8, 5'd8);
    branch_taken = 1'b1;
    step("br_flush", 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    branch_taken = 1'b0;
    id_nop();                  run_idle("br_no_extra", 3'd0, 3'd0);
                               run_idle("br_c4", 3'd0, 3'd0);

    // Fill EX/MEM/WB, request halt, drain for 3 cycles
    id_alu(5'd3, 5'd1, 5'd2);  run_idle("halt_fill1", 3'd0, 3'd0);
    id_alu(5'd4, 5'd6, 5'd7);  run_idle("halt_fill2", 3'd0, 3'd0);
    id_alu(5'd5, 5'd6, 5'd7);
    halt_req = 1'b1;           run_idle("halt_req_run", 3'd0, 3'd0);
    id_alu(5'd9, 5'd6, 5'd7);  // held in ID throughout the halt
    drain_chk("drain1");
    drain_chk("drain2");
    drain_chk("drain3");
    for (int i = 0; i < 10; i++) halted_chk($sformatf("halted_%0d", i));

    // Single step: exactly one enabled cycle, then back to HALTED
    step_in = 1'b1;            halted_chk("step_req");
    step_in = 1'b0;
    step("step_cycle", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
    halted_chk("step_back");
    halted_chk("step_frozen");

    // Release: RUN next cycle; stepped instruction ($9 producer) was held in EX
    halt_req = 1'b0;           halted_chk("release_req");
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
                               run_idle("release_run", 3'd0, 3'd0);
    id_nop();                  run_idle("release_fwd", 3'd1, 3'd0);
                               run_idle("release_c3", 3'd0, 3'd0);
                               run_idle("release_c4", 3'd0, 3'd0);

    // Halt in the same cycle as a load-use: stall now, DRAIN next
    id_lw(5'd8, 5'd9);         run_idle("hl_c1", 3'd0, 3'd0);
    id_alu(5'd10, 5'd8, 5'd8);
    halt_req = 1'b1;
    step("hl_stall_run", 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    drain_chk("hl_drain");

    // Reset mid-DRAIN takes effect before any clock edge
    #2;
    rst_n = 1'b0;
    halt_req = 1'b0;
    #1;
    n_cmp++;
    assert ({fwd_a, fwd_b, stall, bubble, flush, pipe_en, halted, state} === 13'b000_000_0_0_0_1_0_00)
    else begin
      n_fail++;
      $error("FAIL reset_async observed state=%0d pipe_en=%b stall=%b bubble=%b expected state=0 pipe_en=1 stall=0 bubble=0",
             state, pipe_en, stall, bubble);
    end
    // ID still shows the dependent add; slots must have been cleared.
    step("reset_mid_drain", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    rst_n = 1'b1;
    id_nop();
    run_idle("after_reset", 3'd0, 3'd0);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
